instr_mem_responder: RTL

- Instruction-memory slave at the far end of the fetch request/acknowledge interface. It answers the fetch stage's request strobe and address with one instruction word and a one-cycle acknowledge.
- Wait-state latency is programmable, so fetch stall and flush paths can be exercised.
- A side write port loads the program image before or during simulation.
- The block sits between the fetch stage and the bench/SoC memory model.

---
 rtl/instr_mem_pkg.sv | 17 +
 rtl/instr_mem_array.sv | 39 +++
 rtl/instr_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pkg
// Description : Shared constants for the instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  WAIT      = 2'd1;
    localparam logic [1:0]  RESP      = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          LAT_CW    = 4;

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_array
// Description : Word array, one write port and one read port, write-first.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Read data is captured by the caller's output register on the same edge
    // as the write, so a colliding write must be forwarded here.
    always_comb begin
        o_rd_data = mem_q[i_rd_addr];
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            o_rd_data = i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Fetch-side instruction memory slave with programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder #(
    parameter int                IWIDTH       = 32,
    parameter int                AWIDTH_INSTR = 32,
    parameter int                DEPTH_LOG2   = 10,
    parameter int                LATENCY      = 2,
    parameter logic [IWIDTH-1:0] NOP_INSTR    = IWIDTH'(instr_mem_pkg::NOP_INSTR)
) (
    input  logic                    im_clk,
    input  logic                    im_rst,
    input  logic                    im_i_syn,
    input  logic [AWIDTH_INSTR-1:0] im_i_addr,
    output logic [IWIDTH-1:0]       im_o_instr,
    output logic                    im_o_ack,
    output logic                    im_o_err,
    output logic                    im_o_busy,
    input  logic                    im_i_wr_en,
    input  logic [DEPTH_LOG2-1:0]   im_i_wr_addr,
    input  logic [IWIDTH-1:0]       im_i_wr_data
);

    import instr_mem_pkg::*;

    logic [1:0]              state_q, state_d;
    logic [LAT_CW-1:0]       cnt_q, cnt_d;
    logic [AWIDTH_INSTR-1:0] addr_q, addr_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [IWIDTH-1:0]       instr_q, instr_d;

    logic [AWIDTH_INSTR-1:0] rd_byte_addr;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    addr_err;
    logic [IWIDTH-1:0]       rd_data;
    logic [LAT_CW-1:0]       cnt_dec;
    logic                    enter_resp;

    // With LATENCY=1 the read happens on the accept edge, before capture.
    always_comb begin
        rd_byte_addr = (state_q == IDLE) ? im_i_addr : addr_q;
        rd_idx       = rd_byte_addr[DEPTH_LOG2+1:2];
        addr_err     = (rd_byte_addr[1:0] != 2'b00) ||
                       ((rd_byte_addr >> (DEPTH_LOG2 + 2)) != '0);
        cnt_dec      = cnt_q - LAT_CW'(1);
    end

    instr_mem_array #(
        .DWIDTH (IWIDTH),
        .AWIDTH (DEPTH_LOG2)
    ) u_array (
        .clk       (im_clk),
        .i_wr_en   (im_i_wr_en),
        .i_wr_addr (im_i_wr_addr),
        .i_wr_data (im_i_wr_data),
        .i_rd_addr (rd_idx),
        .o_rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (im_i_syn) begin
                    addr_d = im_i_addr;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // A dropped strobe is the fetch stage flushing this request.
                if (!im_i_syn) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ack_d   = enter_resp;
        err_d   = enter_resp & addr_err;
        instr_d = !enter_resp ? '0 : (addr_err ? NOP_INSTR : rd_data);
        busy_d  = (state_d == WAIT);
    end

    always_ff @(posedge im_clk) begin
        if (im_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            instr_q <= instr_d;
        end
    end

    assign im_o_instr = instr_q;
    assign im_o_ack   = ack_q;
    assign im_o_err   = err_q;
    assign im_o_busy  = busy_q;

endmodule
`default_nettype wire
